fir_tap_delay_line: RTL and testbench



---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_tap_reg.sv | 45 ++++
 rtl/fir_tap_delay_line.sv | 123 ++++++++++++
 tb/tb_fir_tap_delay_line.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared constants and helpers for the FIR datapath blocks (delay line, MAC).
//   FIR_DATA_W / FIR_DEPTH : default sample width and tap count.
//   cnt_w()                : width of a counter that must hold 0..depth.
//   tap_lsb()              : LSB index of tap k in a flattened tap bus, where
//                            tap k sits at [k*data_w +: data_w] and tap 0 is
//                            the newest sample.
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_DEPTH  = 8;

  // Bits needed to represent every value in 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Position of tap k inside the flattened tap vector.
  function automatic int tap_lsb(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage : fir_pkg

// File: rtl/fir_tap_reg.sv
// -----------------------------------------------------------------------------
// fir_tap_reg
// One storage element of the tap delay line.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset, clears q
//   clr    in   synchronous clear, wins over load
//   load   in   capture d on this edge
//   d      in   DATA_W  next sample value
//   q      out  DATA_W  stored sample
// -----------------------------------------------------------------------------
module fir_tap_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_d;
  logic [DATA_W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : fir_tap_reg

// File: rtl/fir_tap_delay_line.sv
// -----------------------------------------------------------------------------
// fir_tap_delay_line
// Sample delay line feeding the FIR multiply-accumulate stage. Keeps the last
// DEPTH accepted samples and presents them in parallel on a flattened bus.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   in_valid    in   sample strobe, in_data accepted on every edge it is high
//   in_data     in   DATA_W input sample
//   flush       in   synchronous clear of line and fill state (drops a
//                    coincident sample)
//   taps        out  DATA_W*DEPTH, tap k at [k*DATA_W +: DATA_W], tap 0 newest
//   out_valid   out  one-cycle pulse, taps hold a fresh window for a MAC pass
//   primed      out  line holds DEPTH real samples
//   fill_count  out  CNT_W accepted samples since reset/flush, saturating
// Parameters:
//   ZERO_FILL = 0 : out_valid only once the line is full
//   ZERO_FILL = 1 : out_valid on every accept; unfilled taps read as zero
//                   (they are cleared by reset/flush, so no masking needed)
// -----------------------------------------------------------------------------
module fir_tap_delay_line
  import fir_pkg::*;
#(
  parameter  int DATA_W    = FIR_DATA_W,
  parameter  int DEPTH     = FIR_DEPTH,
  parameter  int ZERO_FILL = 0,
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    flush,
  output logic [DATA_W*DEPTH-1:0] taps,
  output logic                    out_valid,
  output logic                    primed,
  output logic [CNT_W-1:0]        fill_count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  // flush beats in_valid: a coincident sample is dropped.
  logic accept;
  assign accept = in_valid & ~flush;

  // ---------------------------------------------------------------------------
  // Tap storage: tap 0 loads the input, tap k loads tap k-1 (shift on accept)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] tap_val [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    localparam int LSB = tap_lsb(k, DATA_W);
    logic [DATA_W-1:0] tap_in;

    if (k == 0) begin : g_head
      assign tap_in = in_data;
    end else begin : g_body
      assign tap_in = tap_val[k-1];
    end

    fir_tap_reg #(
      .DATA_W (DATA_W)
    ) u_tap (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .load  (accept),
      .d     (tap_in),
      .q     (tap_val[k])
    );

    assign taps[LSB +: DATA_W] = tap_val[k];
  end

  // ---------------------------------------------------------------------------
  // Fill / valid control
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] fill_count_d;
  logic [CNT_W-1:0] fill_count_q;
  logic             primed_d;
  logic             primed_q;
  logic             out_valid_d;
  logic             out_valid_q;
  logic             qualifies;

  // Using the pre-accept count lets out_valid rise on the same edge that
  // writes the window it describes.
  assign qualifies = (ZERO_FILL != 0) ? 1'b1 : (fill_count_q >= LAST_CNT);

  always_comb begin
    fill_count_d = fill_count_q;
    out_valid_d  = 1'b0;
    if (flush) begin
      fill_count_d = '0;
    end else if (accept) begin
      if (fill_count_q != FULL_CNT) begin
        fill_count_d = fill_count_q + CNT_W'(1);
      end
      out_valid_d = qualifies;
    end
    // Registered copy of (fill_count == DEPTH) so primed tracks the count
    // in the same cycle without a combinational compare on the output.
    primed_d = (fill_count_d == FULL_CNT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_count_q <= '0;
      primed_q     <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      fill_count_q <= fill_count_d;
      primed_q     <= primed_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign fill_count = fill_count_q;
  assign primed     = primed_q;
  assign out_valid  = out_valid_q;

endmodule : fir_tap_delay_line

// File: tb/tb_fir_tap_delay_line.sv
module tb_fir_tap_delay_line;

  localparam int DW = 16;
  localparam int DP = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            flush;

  logic [DW*DP-1:0] taps0, taps1;
  logic             ov0, ov1;
  logic             pr0, pr1;
  logic [CW-1:0]    fc0, fc1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fir_tap_delay_line #(.DATA_W(DW), .DEPTH(DP), .ZERO_FILL(0)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .flush      (flush),
    .taps       (taps0),
    .out_valid  (ov0),
    .primed     (pr0),
    .fill_count (fc0)
  );

  fir_tap_delay_line #(.DATA_W(DW), .DEPTH(DP), .ZERO_FILL(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .flush      (flush),
    .taps       (taps1),
    .out_valid  (ov1),
    .primed     (pr1),
    .fill_count (fc1)
  );

  typedef struct {
    logic          v;
    logic          f;
    logic [15:0]   d;
    logic [63:0]   exp_taps;   // {tap3, tap2, tap1, tap0}
    logic [2:0]    exp_fill;
    logic          exp_ov0;    // ZERO_FILL=0 instance
    logic          exp_ov1;    // ZERO_FILL=1 instance
    logic          exp_pr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic f, input logic [15:0] d,
                     input logic [63:0] t, input logic [2:0] fc,
                     input logic o0, input logic o1, input logic p);
    vec_t r;
    r.v = v; r.f = f; r.d = d; r.exp_taps = t; r.exp_fill = fc;
    r.exp_ov0 = o0; r.exp_ov1 = o1; r.exp_pr = p;
    vecs.push_back(r);
  endtask

  task automatic step(input logic v, input logic f, input logic [15:0] d);
    in_valid = v; flush = f; in_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; in_data = '0;

    // Stream 1..4 back-to-back, then one idle cycle
    add(1,0,16'h0001, 64'h0000_0000_0000_0001, 3'd1, 0,1,0);
    add(1,0,16'h0002, 64'h0000_0000_0001_0002, 3'd2, 0,1,0);
    add(1,0,16'h0003, 64'h0000_0001_0002_0003, 3'd3, 0,1,0);
    add(1,0,16'h0004, 64'h0001_0002_0003_0004, 3'd4, 1,1,1);
    add(0,0,16'hDEAD, 64'h0001_0002_0003_0004, 3'd4, 0,0,1);
    add(0,1,16'h0000, 64'h0000_0000_0000_0000, 3'd0, 0,0,0);
    // Same stream with two idle cycles between samples
    add(1,0,16'h0001, 64'h0000_0000_0000_0001, 3'd1, 0,1,0);
    add(0,0,16'hAAAA, 64'h0000_0000_0000_0001, 3'd1, 0,0,0);
    add(0,0,16'h5555, 64'h0000_0000_0000_0001, 3'd1, 0,0,0);
    add(1,0,16'h0002, 64'h0000_0000_0001_0002, 3'd2, 0,1,0);
    add(0,0,16'hAAAA, 64'h0000_0000_0001_0002, 3'd2, 0,0,0);
    add(0,0,16'h5555, 64'h0000_0000_0001_0002, 3'd2, 0,0,0);
    add(1,0,16'h0003, 64'h0000_0001_0002_0003, 3'd3, 0,1,0);
    add(0,0,16'hAAAA, 64'h0000_0001_0002_0003, 3'd3, 0,0,0);
    add(0,0,16'h5555, 64'h0000_0001_0002_0003, 3'd3, 0,0,0);
    add(1,0,16'h0004, 64'h0001_0002_0003_0004, 3'd4, 1,1,1);
    add(0,0,16'hAAAA, 64'h0001_0002_0003_0004, 3'd4, 0,0,1);
    add(0,0,16'h5555, 64'h0001_0002_0003_0004, 3'd4, 0,0,1);
    add(0,1,16'h0000, 64'h0000_0000_0000_0000, 3'd0, 0,0,0);
    // Ten samples back-to-back: saturation, seven out_valid cycles
    add(1,0,16'h0010, 64'h0000_0000_0000_0010, 3'd1, 0,1,0);
    add(1,0,16'h0011, 64'h0000_0000_0010_0011, 3'd2, 0,1,0);
    add(1,0,16'h0012, 64'h0000_0010_0011_0012, 3'd3, 0,1,0);
    add(1,0,16'h0013, 64'h0010_0011_0012_0013, 3'd4, 1,1,1);
    add(1,0,16'h0014, 64'h0011_0012_0013_0014, 3'd4, 1,1,1);
    add(1,0,16'h0015, 64'h0012_0013_0014_0015, 3'd4, 1,1,1);
    add(1,0,16'h0016, 64'h0013_0014_0015_0016, 3'd4, 1,1,1);
    add(1,0,16'h0017, 64'h0014_0015_0016_0017, 3'd4, 1,1,1);
    add(1,0,16'h0018, 64'h0015_0016_0017_0018, 3'd4, 1,1,1);
    add(1,0,16'h0019, 64'h0016_0017_0018_0019, 3'd4, 1,1,1);
    add(0,0,16'h0000, 64'h0016_0017_0018_0019, 3'd4, 0,0,1);
    // Flush with coincident sample while primed: sample dropped
    add(1,1,16'hBEEF, 64'h0000_0000_0000_0000, 3'd0, 0,0,0);
    add(0,0,16'h0000, 64'h0000_0000_0000_0000, 3'd0, 0,0,0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset taps",  64'(taps0), 64'h0);
    chk("reset fill",  64'(fc0),   64'h0);
    chk("reset ov",    64'(ov0),   64'h0);
    chk("reset primed",64'(pr0),   64'h0);
    reset = 1'b0;

    // Asynchronous reset mid-stream after three samples
    step(1, 0, 16'h0A01);
    step(1, 0, 16'h0A02);
    step(1, 0, 16'h0A03);
    chk("pre-areset fill", 64'(fc0),   64'd3);
    chk("pre-areset taps", 64'(taps0), 64'h0000_0A01_0A02_0A03);
    chk("pre-areset zf1 ov", 64'(ov1), 64'd1);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("areset taps",    64'(taps0), 64'h0);
    chk("areset fill",    64'(fc0),   64'h0);
    chk("areset primed",  64'(pr0),   64'h0);
    chk("areset ov",      64'(ov0),   64'h0);
    chk("areset zf1 ov",  64'(ov1),   64'h0);
    chk("areset zf1 taps",64'(taps1), 64'h0);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].f, vecs[i].d);
      chk($sformatf("row%0d taps", i),     64'(taps0), vecs[i].exp_taps);
      chk($sformatf("row%0d fill", i),     64'(fc0),   64'(vecs[i].exp_fill));
      chk($sformatf("row%0d out_valid", i),64'(ov0),   64'(vecs[i].exp_ov0));
      chk($sformatf("row%0d primed", i),   64'(pr0),   64'(vecs[i].exp_pr));
      chk($sformatf("row%0d zf1 ov", i),   64'(ov1),   64'(vecs[i].exp_ov1));
      chk($sformatf("row%0d zf1 taps", i), 64'(taps1), vecs[i].exp_taps);
      chk($sformatf("row%0d zf1 fill", i), 64'(fc1),   64'(vecs[i].exp_fill));
    end

    // ZERO_FILL=1: first sample after reset is immediately usable
    reset = 1'b1;
    #2 reset = 1'b0;
    step(1, 0, 16'h7FFF);
    chk("zf1 first ov",     64'(ov1),   64'd1);
    chk("zf1 first taps",   64'(taps1), 64'h0000_0000_0000_7FFF);
    chk("zf1 first primed", 64'(pr1),   64'd0);
    chk("zf1 first fill",   64'(fc1),   64'd1);
    chk("zf0 first ov",     64'(ov0),   64'd0);
    step(0, 0, 16'h0000);
    chk("zf1 idle ov",      64'(ov1),   64'd0);
    chk("zf1 idle taps",    64'(taps1), 64'h0000_0000_0000_7FFF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_fir_tap_delay_line
